// File: rtl/execute_pipe_if.sv
// Decode-side and writeback-side handshake bundle for execute_pipe.
// The master drives operations and out_ready. The slave (the execute unit) drives in_ready and the results.
interface execute_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_jmp;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_jmp
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_jmp
  );
endinterface

// File: rtl/execute_pipe.sv
// Two-stage pass/add/sub/jump execute unit with carry/zero flags and valid/ready on both sides.
// Define EXE_SAT_EN to saturate ADD/ADDC at all-ones and SUB at zero.
module execute_pipe #(
  parameter int unsigned WIDTH        = 16,
  parameter bit          ZERO_ON_PASS = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  execute_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_ADDC = 3'b011,
    OP_JMP  = 3'b100,
    OP_JZ   = 3'b101,
    OP_JC   = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic             add_cin;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_zero;
  logic             nxt_jmp;

  assign s2_free      = !bus.out_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_free;
  assign bus.in_ready = !s1_valid || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;

  // out_carry/out_zero are loaded only when an op enters stage 2, so they double as the flag register.
  // The next op in stage 1 therefore sees the flags of its immediate predecessor.
  always_comb begin
    add_cin    = (s1_op == OP_ADDC) ? bus.out_carry : 1'b0;
    add_sum    = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, add_cin};
    sub_diff   = {1'b0, s1_a} - {1'b0, s1_b};
    nxt_result = s1_b;
    nxt_carry  = bus.out_carry;
    nxt_zero   = bus.out_zero;
    nxt_jmp    = 1'b0;
    case (s1_op)
      OP_PASS: begin
        if (ZERO_ON_PASS) nxt_zero = (s1_b == '0);
      end
      OP_ADD, OP_ADDC: begin
        nxt_carry  = add_sum[WIDTH];
`ifdef EXE_SAT_EN
        nxt_result = add_sum[WIDTH] ? '1 : add_sum[WIDTH-1:0];
`else
        nxt_result = add_sum[WIDTH-1:0];
`endif
        nxt_zero   = (nxt_result == '0);
      end
      OP_SUB: begin
        nxt_carry  = !sub_diff[WIDTH];
`ifdef EXE_SAT_EN
        nxt_result = sub_diff[WIDTH] ? '0 : sub_diff[WIDTH-1:0];
`else
        nxt_result = sub_diff[WIDTH-1:0];
`endif
        nxt_zero   = (nxt_result == '0);
      end
      OP_JMP:  nxt_jmp = 1'b1;
      OP_JZ:   nxt_jmp = bus.out_zero;
      OP_JC:   nxt_jmp = bus.out_carry;
      OP_NOP:  nxt_result = s1_a;
      default: nxt_result = s1_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_PASS;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op_e'(bus.in_op);
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_carry  <= 1'b0;
      bus.out_zero   <= 1'b0;
      bus.out_jmp    <= 1'b0;
    end else if (s1_adv) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= nxt_result;
      bus.out_carry  <= nxt_carry;
      bus.out_zero   <= nxt_zero;
      bus.out_jmp    <= nxt_jmp;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit add/pass execute unit of the video display processor.
- Supports eight opcodes: pass, add, subtract, add-with-carry, and three jump decisions.
- Keeps carry and zero flags in registers.
- Sits between decode and writeback/PC-update. Uses valid/ready handshakes on both sides with fixed 2-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits (≥2).
- ZERO_ON_PASS, 0, when 1, PASS_B also updates the zero flag.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  stage 1 can accept
- in_op  input  3  opcode
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B / jump target
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  WIDTH  result or jump target
- out_carry  output  1  carry flag after this op
- out_zero  output  1  zero flag after this op
- out_jmp  output  1  jump taken (PC-update consumer)

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n): sampled only on the rising clk edge.
- Opcodes:
  - 000 PASS_B: result=b.
  - 001 ADD: {c,r}=a+b.
  - 010 SUB: r=a-b; c=1 when a≥b (no borrow).
  - 011 ADDC: {c,r}=a+b+C.
  - 100 JMP: result=b, jmp=1.
  - 101 JZ: result=b, jmp=Z.
  - 110 JC: result=b, jmp=C.
  - 111 NOP: result=a, jmp=0.
- Arithmetic is WIDTH bits, modulo 2^WIDTH. Carry is bit WIDTH of the (WIDTH+1)-bit sum.
- Flag register (C, Z):
  - ADD/SUB/ADDC update C and Z; Z=(r==0).
  - PASS_B updates Z only when ZERO_ON_PASS=1.
  - Jumps and NOP leave flags unchanged.
  - out_carry/out_zero report the flag register value after the op.
- Pipeline:
  - Stage 1 registers op/a/b on in_valid&&in_ready.
  - Stage 2 registers result/flags/jmp when stage 1 advances.
  - Flag register updates on the same edge the op enters stage 2.
  - A following JZ/JC/ADDC therefore sees the flags of the immediately preceding op, with no hazard or bubble.
- Latency: result appears exactly 2 cycles after acceptance when out_ready is held high. Throughput is 1 op/cycle.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - s1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free.
  - in_ready is combinational from out_ready (no skid buffer).
  - out_valid stays high and out_* stay stable until out_ready.
  - Ops are never dropped or duplicated; order is preserved.
- Simultaneous events: stage 2 draining while stage 1 advances and a new op is accepted, all in one cycle, is legal and required for full throughput.
- Reset (including mid-operation):
  - Both stage valids clear, so any in-flight ops are discarded.
  - C=Z=0.
  - out_valid=0, out_result=0, out_carry=0, out_zero=0, out_jmp=0.
  - in_ready=1 in the first cycle after reset.
- in_op/in_a/in_b are don't-care while in_valid=0.

Optional Feature:
- EXE_SAT_EN defined:
  - ADD/ADDC results clamp to all-ones on carry out.
  - SUB clamps to 0 on borrow.
  - C still reports the raw carry/borrow.
  - Z is computed on the clamped result.
- Undefined: wrap-around arithmetic only; no clamp logic is synthesised.

Test Plan:
1. Reset then PASS_B a=000A b=0005, out_ready=1 -> out_result=0005 two cycles after accept; C=0, Z=0, jmp=0.
2. ADD FFFF+0001, then JC b=0040, then ADDC 0001+0001 -> results 0000 (C=1, Z=1), 0040 (jmp=1), 0003 (C=0, Z=0).
   - With EXE_SAT_EN: first result is FFFF, Z=0.
3. SUB 0005-0005, then JZ b=0123, then SUB 0003-0005 -> 0000 (C=1, Z=1), jmp=1 result 0123, FFFE (C=0, Z=0).
   - With EXE_SAT_EN: third result is 0000, Z=1.
4. Back-to-back stream of 8 ops with out_ready toggling 1,0,0,1,... -> every op emerges once, in order, with out_* stable while stalled.
   - in_ready falls only when both stages are full and out_ready=0.
5. rst_n low for one cycle with 2 ops in flight -> next cycle out_valid=0 and all outputs/flags 0.
   - The in-flight ops never appear.
   - A subsequent JZ is not taken (Z=0).
